// File: rtl/control_fetch_if_id.sv
// Fetch stage: PC register and IF/ID pipeline register with run/single-step control,
// halt detection and debug cycle/stall counters.
//
// state  | meaning
// S_IDLE | pipe frozen, waiting for inicio to drop; step_mode picks RUN or STEP
// S_RUN  | free run, advances every cycle
// S_STEP | single-step, advances once per rising edge of step
// S_HALT | halt opcode reached decode; absorbing until reset
module control_fetch_if_id #(
  parameter int                 PC_W        = 32,
  parameter int                 INSTR_W     = 32,
  parameter logic [PC_W-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = '1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inicio,
  input  logic               step_mode,
  input  logic               step,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [PC_W-1:0]    PCBranchD,
  input  logic [INSTR_W-1:0] InstrF,
  output logic [PC_W-1:0]    PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               halted,
  output logic [31:0]        cycle_cnt,
  output logic [15:0]        stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

  state_t             state_q;
  logic               step_q;
  logic               halted_q;
  logic [PC_W-1:0]    pcf_q, pcf_d;
  logic [INSTR_W-1:0] instrd_q, instrd_d;
  logic [PC_W-1:0]    pcplus4d_q, pcplus4d_d;
  logic [31:0]        cycle_q, cycle_d;
  logic [15:0]        stall_q, stall_d;

  logic [PC_W-1:0]    pc_plus4;
  logic               halt_seen;
  logic               step_pulse;
  logic               adv;

  always_comb begin
    pc_plus4   = pcf_q + PC_W'(4);
    halt_seen  = (instrd_q == HALT_OPCODE);
    step_pulse = step & ~step_q;
    adv        = ((state_q == S_RUN) | ((state_q == S_STEP) & step_pulse))
                 & ~inicio & ~halt_seen;

    pcf_d      = pcf_q;
    instrd_d   = instrd_q;
    pcplus4d_d = pcplus4d_q;
    cycle_d    = cycle_q;
    stall_d    = stall_q;

    if (adv) begin
      if (!StallF) pcf_d = PCSrcD ? PCBranchD : pc_plus4;
      // stall beats flush: a held branch is simply re-evaluated next cycle
      if (!StallD) begin
        if (PCSrcD) begin
          instrd_d   = '0;
          pcplus4d_d = '0;
        end else begin
          instrd_d   = InstrF;
          pcplus4d_d = pc_plus4;
        end
      end
      if (cycle_q != '1)           cycle_d = cycle_q + 32'd1;
      if (StallF && stall_q != '1) stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      step_q <= step;
      case (state_q)
        S_IDLE: if (!inicio) state_q <= step_mode ? S_STEP : S_RUN;
        S_RUN, S_STEP: begin
          if (inicio) begin
            state_q <= S_IDLE;
          end else if (halt_seen) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_HALT:  halted_q <= 1'b1;
        default: state_q  <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcf_q      <= RESET_PC;
      instrd_q   <= '0;
      pcplus4d_q <= '0;
      cycle_q    <= '0;
      stall_q    <= '0;
    end else begin
      pcf_q      <= pcf_d;
      instrd_q   <= instrd_d;
      pcplus4d_q <= pcplus4d_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
    end
  end

  assign PCF       = pcf_q;
  assign InstrD    = instrd_q;
  assign PCPlus4D  = pcplus4d_q;
  assign halted    = halted_q;
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_control_fetch_if_id.sv
// Directed bench for control_fetch_if_id; a second instance with RESET_PC near the top
// of the address space checks PC wrap. Inputs change on negedge, outputs checked on negedge.
module tb_control_fetch_if_id;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inicio, step_mode, step, StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD, InstrF;

  logic [31:0] PCF, InstrD, PCPlus4D, cycle_cnt;
  logic        halted;
  logic [15:0] stall_cnt;

  logic [31:0] w_PCF, w_InstrD, w_PCPlus4D, w_cycle_cnt;
  logic        w_halted;
  logic [15:0] w_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_fetch_if_id dut (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .step_mode(step_mode), .step(step),
    .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  control_fetch_if_id #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .step_mode(step_mode), .step(step),
    .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .InstrF(InstrF), .PCF(w_PCF), .InstrD(w_InstrD), .PCPlus4D(w_PCPlus4D),
    .halted(w_halted), .cycle_cnt(w_cycle_cnt), .stall_cnt(w_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; inicio = 1'b1; step_mode = 1'b0; step = 1'b0;
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = '0; InstrF = '0;
    edges(2);
    reset_n = 1'b1;
    edges(1);
    check("rst_pcf",      PCF,       32'h0);
    check("rst_instrd",   InstrD,    32'h0);
    check("rst_pcplus4d", PCPlus4D,  32'h0);
    check("rst_halted",   {31'b0, halted}, 32'h0);
    check("rst_cycle",    cycle_cnt, 32'h0);
    check("rst_stall",    {16'b0, stall_cnt}, 32'h0);
    check("rst_wrap_pcf", w_PCF,     32'hFFFF_FFFC);
    check("idle_hold_pcf", PCF,      32'h0);

    // run: first edge IDLE->RUN, second edge is the first advance
    inicio = 1'b0; InstrF = 32'h2008_0005;
    edges(1);
    check("enter_run_pcf", PCF, 32'h0);
    edges(1);
    check("run1_instrd",   InstrD,    32'h2008_0005);
    check("run1_pcplus4d", PCPlus4D,  32'h4);
    check("run1_pcf",      PCF,       32'h4);
    check("run1_cycle",    cycle_cnt, 32'd1);
    check("wrap_pcf",      w_PCF,     32'h0);
    check("wrap_pcplus4d", w_PCPlus4D, 32'h0);
    InstrF = 32'h0000_0013;
    edges(1);
    check("run2_pcf",      PCF,       32'h8);
    check("run2_pcplus4d", PCPlus4D,  32'h8);

    // hazards
    StallF = 1'b1; StallD = 1'b1;
    edges(2);
    check("stall_pcf",    PCF,       32'h8);
    check("stall_instrd", InstrD,    32'h13);
    check("stall_cnt2",   {16'b0, stall_cnt}, 32'd2);
    check("stall_cycle",  cycle_cnt, 32'd4);
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h40;
    edges(1);
    check("br_pcf",      PCF,      32'h40);
    check("br_instrd",   InstrD,   32'h0);
    check("br_pcplus4d", PCPlus4D, 32'h0);
    PCSrcD = 1'b0;
    edges(1);
    check("post_br_pcplus4d", PCPlus4D, 32'h44);
    StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h80;
    edges(1);
    check("stalld_br_pcf",      PCF,      32'h80);
    check("stalld_br_instrd",   InstrD,   32'h13);
    check("stalld_br_pcplus4d", PCPlus4D, 32'h44);
    StallD = 1'b0; StallF = 1'b1; PCBranchD = 32'h100;
    edges(1);
    check("stallf_br_pcf",    PCF,      32'h80);
    check("stallf_br_instrd", InstrD,   32'h0);
    check("stallf_br_stall",  {16'b0, stall_cnt}, 32'd3);
    StallF = 1'b0; PCSrcD = 1'b0;
    inicio = 1'b1;
    edges(1);
    check("inicio_hold_pcf",   PCF,       32'h80);
    check("inicio_hold_cycle", cycle_cnt, 32'd8);

    // single step
    inicio = 1'b0; step_mode = 1'b1;
    edges(1);
    step = 1'b1;
    edges(5);
    check("step_once_pcf",   PCF,       32'h84);
    check("step_once_cycle", cycle_cnt, 32'd9);
    step = 1'b0;
    edges(1);
    check("step_low_pcf", PCF, 32'h84);
    step = 1'b1;
    edges(1);
    check("step_again_pcf",      PCF,      32'h88);
    check("step_again_pcplus4d", PCPlus4D, 32'h88);
    step = 1'b0;

    // halt
    inicio = 1'b1;
    edges(1);
    inicio = 1'b0; step_mode = 1'b0;
    edges(1);
    InstrF = 32'hFFFF_FFFF;
    edges(1);
    check("halt_load_instrd", InstrD, 32'hFFFF_FFFF);
    check("halt_load_pcf",    PCF,    32'h8C);
    check("halt_pre_flag",    {31'b0, halted}, 32'h0);
    InstrF = 32'h13;
    edges(1);
    check("halted_flag", {31'b0, halted}, 32'h1);
    check("halted_pcf",  PCF,             32'h8C);
    for (int i = 0; i < 4; i++) begin
      inicio = ~inicio;
      edges(1);
    end
    inicio = 1'b0;
    edges(2);
    check("halt_sticky_flag",  {31'b0, halted}, 32'h1);
    check("halt_sticky_pcf",   PCF,             32'h8C);
    check("halt_sticky_cycle", cycle_cnt,       32'd11);

    // asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    check("async_pcf",      PCF,       32'h0);
    check("async_instrd",   InstrD,    32'h0);
    check("async_halted",   {31'b0, halted}, 32'h0);
    check("async_cycle",    cycle_cnt, 32'h0);
    check("async_wrap_pcf", w_PCF,     32'hFFFF_FFFC);
    edges(1);
    reset_n = 1'b1;

    // stall counter saturation
    StallF = 1'b1; StallD = 1'b1;
    edges(1);
    edges(65534);
    check("stall_near_max", {16'b0, stall_cnt}, 32'h0000_FFFE);
    edges(1);
    check("stall_max",      {16'b0, stall_cnt}, 32'h0000_FFFF);
    edges(2);
    check("stall_sat",      {16'b0, stall_cnt}, 32'h0000_FFFF);
    check("sat_cycle",      cycle_cnt,          32'd65537);
    check("sat_pcf_hold",   PCF,                32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
